// File: rtl/arcade_input_conditioner_pkg.sv
// Shared constants and types for the arcade input conditioner.
package input_cond_pkg;

  // PS/2 set-2 scan codes recognised by the keyboard decoder
  localparam logic [7:0] SC_START1  = 8'h16;
  localparam logic [7:0] SC_START2  = 8'h1E;
  localparam logic [7:0] SC_COIN1   = 8'h2E;
  localparam logic [7:0] SC_COIN2   = 8'h36;
  localparam logic [7:0] SC_SERVICE = 8'h46;
  localparam logic [7:0] SC_PAUSE   = 8'h4D;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_FIRE    = 8'h14;

  // Joystick word bit positions (same map for both pads)
  localparam int JOY_R     = 0;
  localparam int JOY_L     = 1;
  localparam int JOY_D     = 2;
  localparam int JOY_U     = 3;
  localparam int JOY_FIRE  = 4;
  localparam int JOY_START = 5;
  localparam int JOY_COIN  = 6;
  localparam int JOY_PAUSE = 7;

  // Positions inside the merged, active-high button vector
  localparam int B_P1_R    = 0;
  localparam int B_P1_L    = 1;
  localparam int B_P1_D    = 2;
  localparam int B_P1_U    = 3;
  localparam int B_P1_FIRE = 4;
  localparam int B_START1  = 5;
  localparam int B_P2_R    = 6;
  localparam int B_P2_L    = 7;
  localparam int B_P2_D    = 8;
  localparam int B_P2_U    = 9;
  localparam int B_P2_FIRE = 10;
  localparam int B_START2  = 11;
  localparam int B_COIN1   = 12;
  localparam int B_COIN2   = 13;
  localparam int B_SERVICE = 14;
  localparam int B_PAUSE   = 15;
  localparam int NUM_BTN   = 16;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  // Latched keyboard state, 1 = key held
  typedef struct packed {
    logic start1;
    logic start2;
    logic coin1;
    logic coin2;
    logic service;
    logic pause;
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
  } key_state_t;

endpackage

// File: rtl/arcade_input_conditioner_if.sv
// Bundle between the host side (hps_io / PS2 / pads) and the core control inputs.
interface arcade_input_conditioner_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [1:0]  coin;
  logic        btn_service;
  logic [1:0]  btn_start;
  logic [3:0]  p1_joystick;
  logic [3:0]  p2_joystick;
  logic        p1_fire;
  logic        p2_fire;
  logic        pause_btn;

  // host side: drives raw inputs, observes conditioned controls
  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  coin, btn_service, btn_start, p1_joystick, p2_joystick,
           p1_fire, p2_fire, pause_btn
  );

  // conditioner side
  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output coin, btn_service, btn_start, p1_joystick, p2_joystick,
           p1_fire, p2_fire, pause_btn
  );
endinterface

// File: rtl/arcade_input_conditioner_debounce.sv
// Vector debouncer: each bit follows its raw input only after the raw level
// has held unchanged long enough. Raw edge to output edge is CYCLES+1 clocks.
module input_debounce #(
  parameter int WIDTH  = 16,
  parameter int CYCLES = 49152
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int            CW   = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0]         raw_q, raw_d;
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // Per-bit down-counter: reloaded on any raw change, adopt raw level at terminal count
  always_comb begin
    raw_d    = raw;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (raw[i] != raw_q[i]) begin
        cnt_d[i] = LAST;
      end else if (raw_q[i] != stable_q[i]) begin
        if (cnt_q[i] == '0) begin
          stable_d[i] = raw_q[i];
          cnt_d[i]    = LAST;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end else begin
        cnt_d[i] = LAST;
      end
    end
  end

  // State registers; reset leaves every bit stable-released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q    <= '0;
      stable_q <= '0;
      cnt_q    <= {WIDTH{LAST}};
    end else begin
      raw_q    <= raw_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/arcade_input_conditioner.sv
// Arcade input conditioner: PS/2 key decode, merge with pads, debounce,
// SOCD resolution and coin pulse shaping for the ScooterShooter core.
//
// Coin FSM (one per coin slot)
//   state | meaning
//   IDLE  | output high, waiting for a debounced coin rising edge
//   PULSE | output low for COIN_PULSE_CYCLES
//   GAP   | output high for COIN_GAP_CYCLES, then replay one queued credit
module arcade_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 49152,
  parameter int COIN_PULSE_CYCLES = 4915200,
  parameter int COIN_GAP_CYCLES   = 2457600,
  parameter bit SOCD_NEUTRAL      = 1'b1
) (
  input logic                       clk_49m,
  input logic                       reset,
  arcade_input_conditioner_if.slave io
);

  localparam int CMAX  = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ? COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
  localparam int CNT_W = $clog2(CMAX) + 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP_CYCLES - 1);

  key_state_t         keys_q, keys_d;
  logic               toggle_q, toggle_d;
  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] db;
  logic [1:0]         coin_db;
  logic [1:0]         coin_n;

  // Extended-code flag and upper pad bits are not used by this core
  logic unused_inputs;
  assign unused_inputs = ^{io.ps2_key[8], io.joystick_0[15:8], io.joystick_1[15:8]};

  // Keyboard decode: a flip of ps2_key[10] marks a new make/break event
  always_comb begin
    toggle_d = io.ps2_key[10];
    keys_d   = keys_q;
    if (io.ps2_key[10] != toggle_q) begin
      case (io.ps2_key[7:0])
        SC_START1:  keys_d.start1  = io.ps2_key[9];
        SC_START2:  keys_d.start2  = io.ps2_key[9];
        SC_COIN1:   keys_d.coin1   = io.ps2_key[9];
        SC_COIN2:   keys_d.coin2   = io.ps2_key[9];
        SC_SERVICE: keys_d.service = io.ps2_key[9];
        SC_PAUSE:   keys_d.pause   = io.ps2_key[9];
        SC_UP:      keys_d.up      = io.ps2_key[9];
        SC_DOWN:    keys_d.down    = io.ps2_key[9];
        SC_LEFT:    keys_d.left    = io.ps2_key[9];
        SC_RIGHT:   keys_d.right   = io.ps2_key[9];
        SC_FIRE:    keys_d.fire    = io.ps2_key[9];
        default:    ;
      endcase
    end
  end

  // Keyboard latch registers
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      keys_q   <= '0;
      toggle_q <= 1'b0;
    end else begin
      keys_q   <= keys_d;
      toggle_q <= toggle_d;
    end
  end

  // Merge keyboard with pads; keyboard directions and fire feed both players
  always_comb begin
    raw            = '0;
    raw[B_P1_R]    = keys_q.right  | io.joystick_0[JOY_R];
    raw[B_P1_L]    = keys_q.left   | io.joystick_0[JOY_L];
    raw[B_P1_D]    = keys_q.down   | io.joystick_0[JOY_D];
    raw[B_P1_U]    = keys_q.up     | io.joystick_0[JOY_U];
    raw[B_P1_FIRE] = keys_q.fire   | io.joystick_0[JOY_FIRE];
    raw[B_START1]  = keys_q.start1 | io.joystick_0[JOY_START];
    raw[B_P2_R]    = keys_q.right  | io.joystick_1[JOY_R];
    raw[B_P2_L]    = keys_q.left   | io.joystick_1[JOY_L];
    raw[B_P2_D]    = keys_q.down   | io.joystick_1[JOY_D];
    raw[B_P2_U]    = keys_q.up     | io.joystick_1[JOY_U];
    raw[B_P2_FIRE] = keys_q.fire   | io.joystick_1[JOY_FIRE];
    raw[B_START2]  = keys_q.start2 | io.joystick_1[JOY_START];
    raw[B_COIN1]   = keys_q.coin1  | io.joystick_0[JOY_COIN] | io.joystick_1[JOY_COIN];
    raw[B_COIN2]   = keys_q.coin2;
    raw[B_SERVICE] = keys_q.service;
    raw[B_PAUSE]   = keys_q.pause  | io.joystick_0[JOY_PAUSE] | io.joystick_1[JOY_PAUSE];
  end

  input_debounce #(
    .WIDTH  (NUM_BTN),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk_49m),
    .rst    (reset),
    .raw    (raw),
    .stable (db)
  );

  assign coin_db = {db[B_COIN2], db[B_COIN1]};

  for (genvar c = 0; c < 2; c++) begin : g_coin
    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             prev_q, prev_d;
    logic             out_n_q, out_n_d;
    logic             rise;

    // Next-state: one queued credit at most, replayed after the gap
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      prev_d  = coin_db[c];
      rise    = coin_db[c] & ~prev_q;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PULSE;
            cnt_d   = PULSE_LAST;
          end
        end
        PULSE: begin
          if (rise) pend_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LAST;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            if (pend_q || rise) begin
              state_d = PULSE;
              cnt_d   = PULSE_LAST;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (rise) pend_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      endcase
      out_n_d = (state_d != PULSE);
    end

    // State register; output flop tracks the state it enters on the same edge
    always_ff @(posedge clk_49m or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        prev_q  <= 1'b0;
        out_n_q <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        prev_q  <= prev_d;
        out_n_q <= out_n_d;
      end
    end

    assign coin_n[c] = out_n_q;
  end

  logic       p1_u, p1_dn, p1_l, p1_r, p2_u, p2_dn, p2_l, p2_r;
  logic [3:0] p1_joy_q, p1_joy_d, p2_joy_q, p2_joy_d;
  logic [1:0] start_q, start_d;
  logic       service_q, service_d, p1_fire_q, p1_fire_d, p2_fire_q, p2_fire_d;
  logic       pause_q, pause_d;

  // Opposing-direction resolution and active-low output encoding
  always_comb begin
    p1_u  = db[B_P1_U];
    p1_dn = db[B_P1_D];
    p1_l  = db[B_P1_L];
    p1_r  = db[B_P1_R];
    p2_u  = db[B_P2_U];
    p2_dn = db[B_P2_D];
    p2_l  = db[B_P2_L];
    p2_r  = db[B_P2_R];
    if (SOCD_NEUTRAL) begin
      if (p1_u && p1_dn) begin p1_u = 1'b0; p1_dn = 1'b0; end
      if (p1_l && p1_r)  begin p1_l = 1'b0; p1_r  = 1'b0; end
      if (p2_u && p2_dn) begin p2_u = 1'b0; p2_dn = 1'b0; end
      if (p2_l && p2_r)  begin p2_l = 1'b0; p2_r  = 1'b0; end
    end
    p1_joy_d  = ~{p1_dn, p1_u, p1_r, p1_l};
    p2_joy_d  = ~{p2_dn, p2_u, p2_r, p2_l};
    start_d   = ~{db[B_START2], db[B_START1]};
    service_d = ~db[B_SERVICE];
    p1_fire_d = ~db[B_P1_FIRE];
    p2_fire_d = ~db[B_P2_FIRE];
    pause_d   = db[B_PAUSE];
  end

  // Output registers; reset forces every control to released
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      p1_joy_q  <= 4'hF;
      p2_joy_q  <= 4'hF;
      start_q   <= 2'b11;
      service_q <= 1'b1;
      p1_fire_q <= 1'b1;
      p2_fire_q <= 1'b1;
      pause_q   <= 1'b0;
    end else begin
      p1_joy_q  <= p1_joy_d;
      p2_joy_q  <= p2_joy_d;
      start_q   <= start_d;
      service_q <= service_d;
      p1_fire_q <= p1_fire_d;
      p2_fire_q <= p2_fire_d;
      pause_q   <= pause_d;
    end
  end

  assign io.coin        = coin_n;
  assign io.btn_service = service_q;
  assign io.btn_start   = start_q;
  assign io.p1_joystick = p1_joy_q;
  assign io.p2_joystick = p2_joy_q;
  assign io.p1_fire     = p1_fire_q;
  assign io.p2_fire     = p2_fire_q;
  assign io.pause_btn   = pause_q;

endmodule
